breakout_game_ctrl: RTL and testbench

//  Top-level game sequencer for the VGA Breakout design. Sits between the player

---
 rtl/breakout_game_ctrl.sv | 132 +++++++++++++
 tb/tb_breakout_game_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_game_ctrl.sv
// rtl/breakout_game_ctrl.sv - Breakout game sequencer: serve/play/pause/over/win, lives and score
module breakout_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int LIVES_W      = 2,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int NBRICK       = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               ball_lost,
  input  logic               brick_hit,
  input  logic [NBRICK-1:0]  brick,
  output logic [2:0]         state,
  output logic               move_en,
  output logic               ball_reset,
  output logic               brick_load,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               go,
  output logic               finish
);

  localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } st_t;

  st_t                st_q, st_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LIVES_W-1:0] lives_n;
  logic [SCORE_W-1:0] score_n;
  logic               load_n;
  logic               sync1, sync2, sync3, start_p;

  // Button synchronizer and rising-edge detect; a held button gives one start_p
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      start_p <= 1'b0;
    end else begin
      sync1   <= start;
      sync2   <= sync1;
      sync3   <= sync2;
      start_p <= sync2 & ~sync3;
    end
  end

  // Next-state, lives, score and serve-counter decisions
  always_comb begin
    st_n    = st_q;
    lives_n = lives;
    score_n = score;
    cnt_n   = cnt;
    load_n  = 1'b0;
    case (st_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (start_p) begin
          st_n    = S_SERVE;
          lives_n = LIVES_W'(LIVES);
          score_n = '0;
          cnt_n   = '0;
          load_n  = 1'b1;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            st_n  = S_PLAY;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        // A hit always scores, even alongside a win, loss or pause
        if (brick_hit && (score != '1)) score_n = score + SCORE_W'(1);
        if (brick == '0) begin
          st_n = S_WIN;
        end else if (ball_lost) begin
          lives_n = lives - LIVES_W'(1);
          cnt_n   = '0;
          st_n    = (lives == LIVES_W'(1)) ? S_OVER : S_SERVE;
        end else if (start_p) begin
          st_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_p) st_n = S_PLAY;
      end
      default: st_n = S_IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= S_IDLE;
      lives      <= '0;
      score      <= '0;
      cnt        <= '0;
      brick_load <= 1'b0;
      ball_reset <= 1'b1;
      go         <= 1'b0;
      finish     <= 1'b0;
    end else begin
      st_q       <= st_n;
      lives      <= lives_n;
      score      <= score_n;
      cnt        <= cnt_n;
      brick_load <= load_n;
      ball_reset <= (st_n == S_IDLE) || (st_n == S_SERVE);
      go         <= (st_n == S_OVER);
      finish     <= (st_n == S_WIN);
    end
  end

  assign state   = st_q;
  assign move_en = frame_tick && (st_q == S_PLAY);

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb/tb_breakout_game_ctrl.sv - Directed scoreboard bench for breakout_game_ctrl
module tb_breakout_game_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, frame_tick, ball_lost, brick_hit;
  logic [12:0] brick;
  logic [2:0]  state;
  logic        move_en, ball_reset, brick_load, go, finish;
  logic [1:0]  lives;
  logic [3:0]  score;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int loads, me_cnt;

  breakout_game_ctrl #(
    .LIVES(3), .LIVES_W(2), .SCORE_W(4), .SERVE_FRAMES(4), .NBRICK(13)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .ball_lost(ball_lost), .brick_hit(brick_hit), .brick(brick),
    .state(state), .move_en(move_en), .ball_reset(ball_reset),
    .brick_load(brick_load), .lives(lives), .score(score),
    .go(go), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: got %0h with no expectation queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", tag, obs, e);
      end
    end
  endtask

  // Hold the button for 10 clocks, counting brick_load pulses, then let the synchronizer settle
  task automatic press(output int nload);
    nload = 0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (brick_load) nload++;
    end
    start = 1'b0;
    step(4);
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic serve();
    for (int i = 0; i < 4; i++) frame();
  endtask

  task automatic lose();
    ball_lost = 1'b1;
    step(1);
    ball_lost = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; frame_tick = 1'b0;
    ball_lost = 1'b0; brick_hit = 1'b0; brick = 13'h1FFF;
    step(2);
    expect_v(0); check("rst_state", state);
    expect_v(0); check("rst_lives", lives);
    expect_v(0); check("rst_score", score);
    expect_v(1); check("rst_ball_reset", ball_reset);
    expect_v(0); check("rst_go", go);
    expect_v(0); check("rst_finish", finish);
    expect_v(0); check("rst_brick_load", brick_load);
    frame_tick = 1'b1; #1;
    expect_v(0); check("idle_move_en", move_en);
    frame_tick = 1'b0;
    rst = 1'b1;
    step(1);

    // New game and serve countdown
    press(loads);
    expect_v(1); check("new_loads", loads);
    expect_v(1); check("new_state", state);
    expect_v(3); check("new_lives", lives);
    expect_v(0); check("new_score", score);
    expect_v(1); check("serve_ball_reset", ball_reset);
    for (int i = 0; i < 3; i++) frame();
    expect_v(1); check("serve_3ticks", state);
    frame();
    expect_v(2); check("serve_4ticks", state);
    expect_v(0); check("play_ball_reset", ball_reset);
    frame_tick = 1'b1; #1;
    expect_v(1); check("play_move_en", move_en);
    step(1);
    frame_tick = 1'b0;

    // Scoring with saturation
    brick_hit = 1'b1; step(3); brick_hit = 1'b0;
    expect_v(3); check("score_3", score);
    brick_hit = 1'b1; step(17); brick_hit = 1'b0;
    expect_v(15); check("score_sat", score);

    // Pause freezes motion and ignores events
    press(loads);
    expect_v(3); check("pause_state", state);
    me_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1; #1;
      if (move_en) me_cnt++;
      step(1);
      frame_tick = 1'b0;
    end
    expect_v(0); check("pause_move_en", me_cnt);
    lose();
    expect_v(3); check("pause_lost_state", state);
    expect_v(3); check("pause_lost_lives", lives);

    // Resume while frame_tick is high: no step while still paused
    frame_tick = 1'b1;
    start = 1'b1;
    me_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (state == 3'd3 && move_en) me_cnt++;
      step(1);
    end
    start = 1'b0;
    frame_tick = 1'b0;
    step(4);
    expect_v(0); check("resume_move_en", me_cnt);
    expect_v(2); check("resume_state", state);
    frame_tick = 1'b1; #1;
    expect_v(1); check("resume_tick", move_en);
    step(1);
    frame_tick = 1'b0;

    // Losing all lives
    lose();
    expect_v(1); check("lost1_state", state);
    expect_v(2); check("lost1_lives", lives);
    expect_v(1); check("lost1_ball_reset", ball_reset);
    press(loads);
    expect_v(1); check("serve_start_state", state);
    expect_v(0); check("serve_start_loads", loads);
    serve();
    expect_v(2); check("replay1_state", state);
    lose();
    expect_v(1); check("lost2_state", state);
    expect_v(1); check("lost2_lives", lives);
    serve();
    lose();
    expect_v(4); check("lost3_state", state);
    expect_v(0); check("lost3_lives", lives);
    expect_v(1); check("over_go", go);
    expect_v(15); check("over_score", score);

    // Restart from OVER
    press(loads);
    expect_v(1); check("restart_loads", loads);
    expect_v(1); check("restart_state", state);
    expect_v(3); check("restart_lives", lives);
    expect_v(0); check("restart_score", score);
    expect_v(0); check("restart_go", go);

    // Empty mask in SERVE must not win
    brick = 13'h0000;
    step(2);
    expect_v(1); check("serve_empty_mask", state);
    brick = 13'h1FFF;
    serve();
    brick_hit = 1'b1; step(1); brick_hit = 1'b0;
    expect_v(1); check("play_hit1", score);

    // Last brick cleared with simultaneous ball loss and hit
    brick = 13'h0001;
    step(1);
    brick = 13'h0000; ball_lost = 1'b1; brick_hit = 1'b1;
    step(1);
    ball_lost = 1'b0; brick_hit = 1'b0;
    expect_v(5); check("win_state", state);
    expect_v(1); check("win_finish", finish);
    expect_v(3); check("win_lives", lives);
    expect_v(2); check("win_score", score);
    expect_v(0); check("win_go", go);
    brick = 13'h1FFF;
    press(loads);
    expect_v(1); check("win_restart_loads", loads);
    expect_v(1); check("win_restart_state", state);
    expect_v(0); check("win_restart_finish", finish);

    // Asynchronous reset mid-PLAY
    serve();
    brick_hit = 1'b1; step(1); brick_hit = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    expect_v(0); check("arst_state", state);
    expect_v(0); check("arst_lives", lives);
    expect_v(0); check("arst_score", score);
    expect_v(1); check("arst_ball_reset", ball_reset);
    #1 rst = 1'b1;
    step(1);
    press(loads);
    expect_v(1); check("arst_loads", loads);
    expect_v(1); check("arst_state_serve", state);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
